// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution MAC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package conv_pkg;

    localparam int CONV_DW   = 8;   // fixed by the 8x8 sign_mul
    localparam int CONV_TAPS = 4;
    localparam int CONV_ACCW = 20;  // >= 2*DW + clog2(TAPS) + 1 for the default kernel

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    typedef logic signed [CONV_DW-1:0]   sample_t;
    typedef logic signed [CONV_ACCW-1:0] acc_t;

endpackage

// File: rtl/conv_mac_sched_if.sv
// Bundle of the coefficient-load, sample-in and result-out ports of conv_mac_sched.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Ports: coef_we/coef_addr/coef_data/coef_drop (config), in_valid/in_ready/in_sample,
//        out_valid/out_ready/out_data. master = sample source/consumer side, slave = the block.
interface conv_mac_sched_if
    import conv_pkg::*;
#(
    parameter int TAPS = CONV_TAPS,
    parameter int DW   = CONV_DW,
    parameter int ACCW = CONV_ACCW
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic                   coef_we;
    logic [AW-1:0]          coef_addr;
    logic signed [DW-1:0]   coef_data;
    logic                   coef_drop;

    logic                   in_valid;
    logic                   in_ready;
    logic signed [DW-1:0]   in_sample;

    logic                   out_valid;
    logic                   out_ready;
    logic signed [ACCW-1:0] out_data;

    modport master (
        output coef_we, coef_addr, coef_data, in_valid, in_sample, out_ready,
        input  coef_drop, in_ready, out_valid, out_data
    );

    modport slave (
        input  coef_we, coef_addr, coef_data, in_valid, in_sample, out_ready,
        output coef_drop, in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sign_mul.sv
// Signed 8x8 -> 16 multiplier shared by all taps of the convolution.
// Latency: combinational.
// Backpressure: none.
// Ports: A, B signed operands; P full-width signed product.
module sign_mul
    import conv_pkg::*;
(
    input  sample_t                     A,
    input  sample_t                     B,
    output logic signed [2*CONV_DW-1:0] P
);

    assign P = A * B;

endmodule

// File: rtl/conv_mac_sched.sv
// FIR/convolution sequencer: one shared multiplier walks all taps of each accepted sample.
// Latency: out_valid rises TAPS cycles after the accept edge; initiation interval TAPS+2.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE and during rst.
// Ports: clk, rst (sync, active-high), bus (conv_mac_sched_if.slave).
module conv_mac_sched
    import conv_pkg::*;
#(
    parameter int TAPS = CONV_TAPS,
    parameter int DW   = CONV_DW,
    parameter int ACCW = CONV_ACCW
) (
    input  logic             clk,
    input  logic             rst,
    conv_mac_sched_if.slave  bus
);

    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW = 2 * DW;

    conv_state_t            state;
    logic [AW-1:0]          k;
    logic signed [ACCW-1:0] acc;
    sample_t                line [TAPS];
    sample_t                coef [TAPS];

    logic signed [ACCW-1:0] out_data_q;
    logic                   out_valid_q;
    logic                   coef_drop_q;

    sample_t                mul_a;
    sample_t                mul_b;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_next;
    logic                   addr_ok;
    logic                   coef_wr;

    // Tap index selects both multiplier operands.
    assign mul_a = coef[k];
    assign mul_b = line[k];

    sign_mul u_mul (
        .A (mul_a),
        .B (mul_b),
        .P (prod)
    );

    assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
    assign acc_next = acc + prod_ext;

    // Extra zero bit keeps the compare meaningful when TAPS is a power of two.
    assign addr_ok = ({1'b0, bus.coef_addr} < (AW+1)'(TAPS));
    assign coef_wr = (state == IDLE) && bus.coef_we && addr_ok;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.coef_drop = coef_drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            coef_drop_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                line[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            // Any write that is not performed (busy or bad address) is flagged.
            coef_drop_q <= bus.coef_we && !coef_wr;
            // Written at the accept edge too, so the new value is used for that sample.
            if (coef_wr) begin
                coef[bus.coef_addr] <= bus.coef_data;
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            line[i] <= line[i-1];
                        end
                        line[0] <= bus.in_sample;
                        acc     <= '0;
                        k       <= '0;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (k == AW'(TAPS - 1)) begin
                        out_data_q  <= acc_next;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
